// File: rtl/md_unit_pkg.sv
// Shared control encodings for the multiply/divide unit and the decoder.
package md_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_SMULT = 3'd1,
      MD_MULT  = 3'd2,
      MD_SDIV  = 3'd3,
      MD_DIV   = 3'd4
   } md_cal_e;

   typedef enum logic [1:0] {
      MD_WNONE = 2'd0,
      MD_WHI   = 2'd1,
      MD_WLO   = 2'd2
   } md_write_e;

   localparam int DW = 32;

   function automatic logic is_div(md_cal_e op);
      return (op == MD_SDIV) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage <-> multiply/divide unit signal bundle.
interface md_unit_if;
   import md_unit_pkg::*;

   logic            start;
   md_cal_e         md_cal;
   md_write_e       md_write;
   logic [DW-1:0]   a;
   logic [DW-1:0]   b;
   logic            req;
   logic            busy;
   logic [DW-1:0]   hi;
   logic [DW-1:0]   lo;

   modport master (output start, md_cal, md_write, a, b, req,
                   input  busy, hi, lo);
   modport slave  (input  start, md_cal, md_write, a, b, req,
                   output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/div unit holding HI/LO; serves mthi/mtlo and mfhi/mflo.
// Build option MDU_CANCEL_EN: req suppresses the same-cycle start/md_write.
//
// state  | meaning
// S_IDLE | waiting for start or md_write
// S_BUSY | counting down; result commits when count goes 1->0
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset_n,
   md_unit_if.slave  md
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_e;

   state_e          state;
   logic [CW-1:0]   count;
   logic [DW-1:0]   a_q, b_q;
   md_cal_e         op_q;
   logic            flush;

`ifdef MDU_CANCEL_EN
   assign flush = md.req;
`else
   logic unused_req;
   assign flush      = 1'b0;
   assign unused_req = md.req;
`endif

   logic op_valid, start_ok, write_ok;
   assign op_valid = (md.md_cal != MD_NONE) && (md.md_cal <= MD_DIV);
   assign start_ok = md.start && op_valid && !flush;
   assign write_ok = (md.md_write != MD_WNONE) && !flush;

   logic signed [63:0] sa, sb;
   logic [63:0]        prod_s, prod_u;
   assign sa     = {{32{a_q[31]}}, a_q};
   assign sb     = {{32{b_q[31]}}, b_q};
   assign prod_s = sa * sb;
   assign prod_u = {32'b0, a_q} * {32'b0, b_q};

   logic [DW-1:0] mag_a, mag_b, dvs, uq, ur, res_hi, res_lo;
   logic          sgn, res_ok;

   // One unsigned divider serves both forms; signed works on magnitudes.
   always_comb begin
      sgn    = (op_q == MD_SDIV);
      mag_a  = (sgn && a_q[31]) ? -a_q : a_q;
      mag_b  = (sgn && b_q[31]) ? -b_q : b_q;
      dvs    = (b_q == '0) ? 32'd1 : mag_b;
      uq     = mag_a / dvs;
      ur     = mag_a % dvs;
      res_hi = '0;
      res_lo = '0;
      res_ok = 1'b1;
      case (op_q)
         MD_SMULT: {res_hi, res_lo} = prod_s;
         MD_MULT:  {res_hi, res_lo} = prod_u;
         MD_SDIV: begin
            if (b_q == '0) begin
               res_ok = 1'b0;
            end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
               res_lo = 32'h8000_0000;
               res_hi = '0;
            end else begin
               res_lo = (a_q[31] ^ b_q[31]) ? -uq : uq;
               res_hi = a_q[31] ? -ur : ur;
            end
         end
         MD_DIV: begin
            res_ok = (b_q != '0);
            res_lo = uq;
            res_hi = ur;
         end
         default: res_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         md.busy <= 1'b0;
         count   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= MD_NONE;
         md.hi   <= '0;
         md.lo   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  a_q     <= md.a;
                  b_q     <= md.b;
                  op_q    <= md.md_cal;
                  count   <= is_div(md.md_cal) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  state   <= S_BUSY;
                  md.busy <= 1'b1;
               end else if (write_ok) begin
                  if (md.md_write == MD_WHI) md.hi <= md.a;
                  if (md.md_write == MD_WLO) md.lo <= md.a;
               end
            end
            S_BUSY: begin
               count <= count - 1'b1;
               if (count == CW'(1)) begin
                  state   <= S_IDLE;
                  md.busy <= 1'b0;
                  if (res_ok) begin
                     md.hi <= res_hi;
                     md.lo <= res_lo;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: reference model queues expected HI/LO and latency.
module tb_md_unit;
   import md_unit_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

`ifdef MDU_CANCEL_EN
   localparam bit CANCEL = 1'b1;
`else
   localparam bit CANCEL = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   md_unit_if md();

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .md      (md)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ref_hi = '0;
   logic [31:0] ref_lo = '0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Reference behaviour from the arithmetic rules, on 64-bit integers.
   function automatic void model(input md_cal_e op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
      longint          sa, sb;
      longint unsigned ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      case (op)
         MD_SMULT: {h, l} = 64'(sa * sb);
         MD_MULT: begin
            p = ua * ub;
            {h, l} = p;
         end
         MD_SDIV: if (b != 0) begin
            l = 32'(sa / sb);
            h = 32'(sa % sb);
         end
         MD_DIV: if (b != 0) begin
            l = a / b;
            h = a % b;
         end
         default: ;
      endcase
   endfunction

   // Monitor: every busy fall must match the next queued expectation.
   initial begin
      int   blen;
      logic pbusy;
      exp_t e;
      blen  = 0;
      pbusy = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            blen  = 0;
            pbusy = 1'b0;
         end else begin
            if (md.busy) begin
               blen++;
            end else if (pbusy) begin
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_commit: got hi=0x%08h lo=0x%08h required no commit", md.hi, md.lo);
               end else begin
                  e = sb_q.pop_front();
                  check32("mon_hi", md.hi, e.hi);
                  check32("mon_lo", md.lo, e.lo);
                  check32("mon_busy_len", 32'(blen), 32'(e.cycles));
               end
               blen = 0;
            end
            pbusy = md.busy;
         end
      end
   end

   task automatic clear_inputs();
      md.start    = 1'b0;
      md.md_cal   = MD_NONE;
      md.md_write = MD_WNONE;
      md.req      = 1'b0;
   endtask

   // One E-stage instruction: op (or MD_NONE), optional md_write, optional req,
   // optionally followed by a start/mthi attempt while busy.
   task automatic do_instr(input md_cal_e op, input logic [31:0] a, input logic [31:0] b,
                           input md_write_e wr, input logic rq, input logic disturb);
      logic acc, suppress;
      exp_t e;
      suppress = CANCEL && rq;
      acc      = (op != MD_NONE) && !suppress;
      @(posedge clk); #1;
      md.start    = (op != MD_NONE);
      md.md_cal   = op;
      md.md_write = wr;
      md.a        = a;
      md.b        = b;
      md.req      = rq;
      if (acc) begin
         model(op, a, b, ref_hi, ref_lo);
         e.hi     = ref_hi;
         e.lo     = ref_lo;
         e.cycles = (op == MD_SDIV || op == MD_DIV) ? DC : MC;
         sb_q.push_back(e);
      end else if (!suppress) begin
         if (wr == MD_WHI) ref_hi = a;
         if (wr == MD_WLO) ref_lo = a;
      end
      @(posedge clk); #1;
      clear_inputs();
      if (acc && disturb) begin
         @(posedge clk); #1;
         md.start    = 1'b1;
         md.md_cal   = MD_MULT;
         md.md_write = MD_WHI;
         md.a        = $urandom;
         md.b        = $urandom;
         @(posedge clk); #1;
         clear_inputs();
      end
      for (int i = 0; i < 40 && md.busy; i++) @(posedge clk);
      @(negedge clk);
      check32("idle_busy", {31'b0, md.busy}, 32'd0);
      check32("idle_hi", md.hi, ref_hi);
      check32("idle_lo", md.lo, ref_lo);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      md_cal_e     op;
      logic [31:0] ra, rb;
      int          sel;
      clear_inputs();
      md.a = '0;
      md.b = '0;
      #12;
      check32("rst_busy", {31'b0, md.busy}, 32'd0);
      check32("rst_hi", md.hi, 32'd0);
      check32("rst_lo", md.lo, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      do_instr(MD_SMULT, 32'hFFFF_FFFE, 32'd3, MD_WNONE, 1'b0, 1'b0);
      check32("smult_hi", md.hi, 32'hFFFF_FFFF);
      check32("smult_lo", md.lo, 32'hFFFF_FFFA);
      do_instr(MD_DIV, 32'd7, 32'd2, MD_WNONE, 1'b0, 1'b0);
      check32("div_hi", md.hi, 32'd1);
      check32("div_lo", md.lo, 32'd3);
      do_instr(MD_SDIV, 32'hFFFF_FFF9, 32'd2, MD_WNONE, 1'b0, 1'b0);
      check32("sdiv_hi", md.hi, 32'hFFFF_FFFF);
      check32("sdiv_lo", md.lo, 32'hFFFF_FFFD);
      do_instr(MD_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, MD_WNONE, 1'b0, 1'b0);
      check32("sdiv_ovf_hi", md.hi, 32'd0);
      check32("sdiv_ovf_lo", md.lo, 32'h8000_0000);
      do_instr(MD_NONE, 32'h11, 32'd0, MD_WHI, 1'b0, 1'b0);
      do_instr(MD_NONE, 32'h22, 32'd0, MD_WLO, 1'b0, 1'b0);
      do_instr(MD_DIV, 32'd99, 32'd0, MD_WNONE, 1'b0, 1'b0);
      check32("div0_hi", md.hi, 32'h11);
      check32("div0_lo", md.lo, 32'h22);
      do_instr(MD_NONE, 32'h1234, 32'd0, MD_WHI, 1'b0, 1'b0);
      do_instr(MD_NONE, 32'h5678, 32'd0, MD_WLO, 1'b0, 1'b0);
      check32("mthi_hi", md.hi, 32'h1234);
      check32("mtlo_lo", md.lo, 32'h5678);
      do_instr(MD_NONE, 32'hDEAD, 32'hBEEF, MD_WNONE, 1'b0, 1'b0);
      // start wins over md_write; divisor 0 leaves HI untouched
      do_instr(MD_SDIV, 32'hCAFE, 32'd0, MD_WHI, 1'b0, 1'b0);
      do_instr(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_WNONE, 1'b0, 1'b1);
      do_instr(MD_SMULT, 32'h7FFF_FFFF, 32'h8000_0000, MD_WNONE, 1'b1, 1'b0);
      do_instr(MD_NONE, 32'h0BAD, 32'd0, MD_WHI, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         op  = md_cal_e'($urandom_range(1, 4));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
         if (sel <= 5)      do_instr(op, ra, rb, MD_WNONE, 1'b0, 1'($urandom_range(0, 1)));
         else if (sel <= 7) do_instr(MD_NONE, ra, rb, md_write_e'($urandom_range(1, 2)), 1'b0, 1'b0);
         else if (sel == 8) do_instr(MD_NONE, ra, rb, MD_WNONE, 1'b0, 1'b0);
         else               do_instr(op, ra, rb, md_write_e'($urandom_range(0, 2)), 1'b1, 1'b0);
      end

      // Async reset in the third busy cycle discards the pending MULT.
      do_instr(MD_NONE, 32'hAAAA_5555, 32'd0, MD_WHI, 1'b0, 1'b0);
      do_instr(MD_NONE, 32'h5555_AAAA, 32'd0, MD_WLO, 1'b0, 1'b0);
      @(posedge clk); #1;
      md.start  = 1'b1;
      md.md_cal = MD_MULT;
      md.a      = 32'd1000;
      md.b      = 32'd1000;
      @(posedge clk); #1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check32("arst_busy", {31'b0, md.busy}, 32'd0);
      check32("arst_hi", md.hi, 32'd0);
      check32("arst_lo", md.lo, 32'd0);
      ref_hi = '0;
      ref_lo = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      check32("post_rst_busy", {31'b0, md.busy}, 32'd0);
      check32("post_rst_hi", md.hi, 32'd0);
      check32("post_rst_lo", md.lo, 32'd0);

      check32("sb_pending", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
